// File: rtl/aes_round_seq_if.sv
// -----------------------------------------------------------------------------
// aes_round_seq_if
//   Groups the three handshakes of the AES round sequencer into one bundle:
//   the block-input channel, the issue/return channel to the shared
//   single-round datapath, and the finished-block output channel, plus the
//   busy/err status lines.
//
//   modport slave  : the sequencer's view (takes blocks in, drives the
//                    round datapath, hands finished blocks out)
//   modport master : the surrounding system's view (source of blocks, round
//                    datapath, sink of results)
//
//   Signals
//     in_valid / in_ready / in_data        plaintext block in (byte 0 at [127:120])
//     rnd_valid / rnd_data / rnd_idx       one-cycle issue to the round datapath
//     rnd_init / rnd_final                 first-round / last-round controls
//     rnd_ret_valid / rnd_ret_data         round datapath result
//     out_valid / out_ready / out_data     ciphertext block out
//     busy                                 sequencer not idle
//     err                                  one-cycle timeout pulse
// -----------------------------------------------------------------------------
interface aes_round_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;

  logic         rnd_valid;
  logic [127:0] rnd_data;
  logic [3:0]   rnd_idx;
  logic         rnd_init;
  logic         rnd_final;
  logic         rnd_ret_valid;
  logic [127:0] rnd_ret_data;

  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic         busy;
  logic         err;

  modport slave (
    input  in_valid, in_data,
    input  rnd_ret_valid, rnd_ret_data,
    input  out_ready,
    output in_ready,
    output rnd_valid, rnd_data, rnd_idx, rnd_init, rnd_final,
    output out_valid, out_data,
    output busy, err
  );

  modport master (
    output in_valid, in_data,
    output rnd_ret_valid, rnd_ret_data,
    output out_ready,
    input  in_ready,
    input  rnd_valid, rnd_data, rnd_idx, rnd_init, rnd_final,
    input  out_valid, out_data,
    input  busy, err
  );
endinterface

// File: rtl/aes_round_seq.sv
// -----------------------------------------------------------------------------
// aes_round_seq
//   Iterative AES-128 round controller. Takes one 128-bit block, sends it
//   through an external single-round datapath NR+1 times (round index 0..NR),
//   keeps the intermediate state between rounds and returns the finished
//   block on a valid/ready output.
//
//   Parameters
//     NR       number of full rounds (rounds issued with index 0..NR), 1..15
//     TIMEOUT  WAIT cycles without a round return before the block is
//              abandoned; only meaningful when AES_SEQ_TIMEOUT_EN is defined
//
//   Build option
//     AES_SEQ_TIMEOUT_EN  when defined, a wait counter aborts a stalled round
//                         after TIMEOUT cycles and pulses err; when undefined
//                         the controller waits for the round unit forever and
//                         err is tied low.
//
//   Ports
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    aes_round_seq_if.slave (input block, round datapath, output
//            block, busy, err)
//
//   Timing with a round unit of latency L (block accepted in cycle 0):
//     round k issued in cycle 1 + k*(L+1), out_valid first in 1 + (NR+1)*(L+1).
// -----------------------------------------------------------------------------
module aes_round_seq #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  aes_round_seq_if.slave bus
);

  // ---------------------------------------------------------------------------
  // state  | meaning
  // -------+-------------------------------------------------------------------
  // IDLE   | in_ready high, waiting for a plaintext block
  // ISSUE  | rnd_valid high for this single cycle, round r_rnd_cnt presented
  // WAIT   | waiting for the round datapath to return the new state
  // DONE   | out_valid high, out_data held until out_ready
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] NR_IDX = 4'(NR);

  if (NR < 1 || NR > 15) begin : g_bad_nr
    $error("aes_round_seq: NR must be in 1..15");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("aes_round_seq: TIMEOUT must be at least 1");
  end

  state_t       r_state;
  logic [127:0] r_blk;        // block state carried between rounds
  logic [3:0]   r_rnd_cnt;    // current round, 0..NR, never wraps
  logic         r_in_ready;
  logic         r_rnd_valid;
  logic         r_out_valid;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int unsigned         WAIT_W    = $clog2(TIMEOUT + 1);
  // The counter holds j in the (j+1)-th WAIT cycle, so the expiry cycle is
  // the one where it reads TIMEOUT-1 with no return present.
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE  = WAIT_W'(1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_blk       <= '0;
      r_rnd_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_rnd_valid <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
`ifdef AES_SEQ_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_blk       <= bus.in_data;
            r_rnd_cnt   <= '0;
            r_in_ready  <= 1'b0;
            r_rnd_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_rnd_valid <= 1'b0;
          r_state     <= S_WAIT;
`ifdef AES_SEQ_TIMEOUT_EN
          r_wait_cnt  <= '0;
`endif
        end

        S_WAIT: begin
          // A return in the expiry cycle takes priority over the timeout.
          if (bus.rnd_ret_valid) begin
            r_blk <= bus.rnd_ret_data;
            if (r_rnd_cnt == NR_IDX) begin
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_rnd_cnt   <= r_rnd_cnt + 4'd1;
              r_rnd_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (r_wait_cnt == WAIT_LAST) begin
            // Abandon the block; nothing of it is ever presented on out_data.
            r_err      <= 1'b1;
            r_blk      <= '0;
            r_rnd_cnt  <= '0;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
          end
`endif
        end

        S_DONE: begin
          // No same-cycle accept: in_ready only rises in the following IDLE.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_rnd_valid <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.rnd_valid = r_rnd_valid;
  assign bus.rnd_data  = r_blk;
  assign bus.rnd_idx   = r_rnd_cnt;
  assign bus.rnd_init  = (r_rnd_cnt == 4'd0);
  assign bus.rnd_final = (r_rnd_cnt == NR_IDX);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_blk;
  assign bus.busy      = (r_state != S_IDLE);

`ifdef AES_SEQ_TIMEOUT_EN
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
module tb_aes_round_seq;
  localparam int NR      = 10;
  localparam int TIMEOUT = 16;
`ifdef AES_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_round_seq_if bus ();

  aes_round_seq #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Expected timeline of one block, derived from the round-unit latencies.
  typedef struct {
    int issue [16];
    int nissue;
    int done;
    int err_cyc;
  } tl_t;

  int  lat [16];         // stub latency per round index, 0 = never returns
  int  stray_due = -1;   // cycle in which the stub emits an unsolicited return
  int  cyc = 0;

  bit           m_active = 1'b0;
  int           m_acc = 0;
  logic [127:0] m_in = '0;
  tl_t          m_tl;

  int n_cmp  = 0;
  int n_fail = 0;

  int lit_req = 0, lit_seen = 0, lit_kind = 0;

  int           mon_pulses = 0, mon_init = 0, mon_final = 0, mon_err = 0;
  int           mon_out_cyc = -1, mon_err_rel = -1;
  logic [127:0] mon_out_data = '0;

  function automatic logic [127:0] exp_rnd(logic [127:0] b, int k);
    logic [7:0] acc = 8'h00;
    for (int j = 0; j < k; j++) acc ^= 8'(j);
    return b ^ {16{acc}};
  endfunction

  function automatic tl_t calc_tl(int a);
    tl_t t;
    int  c;
    for (int i = 0; i < 16; i++) t.issue[i] = -1;
    t.nissue  = 0;
    t.done    = -1;
    t.err_cyc = -1;
    c = a + 1;
    for (int k = 0; k <= NR; k++) begin
      t.issue[k] = c;
      t.nissue   = k + 1;
      if (lat[k] == 0 || (TO_EN && lat[k] > TIMEOUT)) begin
        if (TO_EN) t.err_cyc = c + TIMEOUT + 1;
        return t;
      end
      c = c + lat[k] + 1;
    end
    t.done = c;
    return t;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: advances on the same edge as the DUT using only bench-driven inputs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_active      <= 1'b0;
      m_tl.err_cyc  <= -1;
    end else if (!m_active) begin
      if (bus.in_valid) begin
        m_active <= 1'b1;
        m_acc    <= cyc;
        m_in     <= bus.in_data;
        m_tl     <= calc_tl(cyc);
      end
    end else if (m_tl.err_cyc > 0 && cyc == m_tl.err_cyc - 1) begin
      m_active <= 1'b0;
    end else if (m_tl.done >= 0 && cyc >= m_tl.done && bus.out_ready) begin
      m_active <= 1'b0;
    end
  end

  // Round-unit stub: ret_data = rnd_data ^ {16{4'h0, rnd_idx}} after lat[idx].
  initial begin
    bit           p_pend = 1'b0;
    int           p_due  = 0;
    logic [127:0] p_data = '0;
    bus.rnd_ret_valid = 1'b0;
    bus.rnd_ret_data  = '0;
    forever begin
      @(negedge clk);
      bus.rnd_ret_valid = 1'b0;
      if (p_pend && cyc == p_due) begin
        bus.rnd_ret_valid = 1'b1;
        bus.rnd_ret_data  = p_data;
        p_pend = 1'b0;
      end
      if (cyc == stray_due) begin
        bus.rnd_ret_valid = 1'b1;
        bus.rnd_ret_data  = '1;
      end
      if (bus.rnd_valid === 1'b1 && lat[bus.rnd_idx] != 0) begin
        p_pend = 1'b1;
        p_due  = cyc + lat[bus.rnd_idx];
        p_data = bus.rnd_data ^ {16{4'h0, bus.rnd_idx}};
      end
    end
  end

  // Compare process: every cycle against the model, plus literal checks.
  initial begin
    logic [127:0] lit_a, lit_b, lit_z;
    lit_a = 128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4;
    lit_b = 128'hf4e5d6c7b0a192837c6d5e4f38291a0b;
    lit_z = 128'h0b0b0b0b0b0b0b0b0b0b0b0b0b0b0b0b;
    forever begin
      bit e_rv, e_ov, e_err;
      int k;
      @(negedge clk);
      if (cyc > 0) begin
        e_rv = 1'b0;
        k    = -1;
        if (m_active)
          for (int j = 0; j < m_tl.nissue; j++)
            if (m_tl.issue[j] == cyc) begin e_rv = 1'b1; k = j; end
        e_ov  = m_active && m_tl.done >= 0 && cyc >= m_tl.done;
        e_err = (m_tl.err_cyc > 0 && cyc == m_tl.err_cyc);

        chk("in_ready",  bus.in_ready,  !m_active);
        chk("busy",      bus.busy,      m_active);
        chk("rnd_valid", bus.rnd_valid, e_rv);
        chk("out_valid", bus.out_valid, e_ov);
        chk("err",       bus.err,       e_err);
        if (e_rv) begin
          chk("rnd_idx",   bus.rnd_idx,   k);
          chk("rnd_init",  bus.rnd_init,  k == 0);
          chk("rnd_final", bus.rnd_final, k == NR);
          chk("rnd_data",  bus.rnd_data,  exp_rnd(m_in, k));
        end
        if (e_ov) chk("out_data", bus.out_data, exp_rnd(m_in, NR + 1));

        if (m_active && cyc == m_acc + 1) begin
          mon_pulses = 0; mon_init = 0; mon_final = 0; mon_err = 0;
          mon_out_cyc = -1; mon_err_rel = -1;
        end
        if (bus.rnd_valid === 1'b1) begin
          mon_pulses++;
          if (bus.rnd_init)  mon_init++;
          if (bus.rnd_final) mon_final++;
        end
        if (bus.out_valid === 1'b1 && mon_out_cyc < 0) begin
          mon_out_cyc  = cyc - m_acc;
          mon_out_data = bus.out_data;
        end
        if (bus.err === 1'b1) begin
          mon_err++;
          mon_err_rel = cyc - m_acc;
        end
      end

      if (lit_req != lit_seen) begin
        lit_seen = lit_req;
        case (lit_kind)
          1: begin
            chk("basic_out_cycle", mon_out_cyc, 23);
            chk("basic_out_data",  mon_out_data, lit_a);
            chk("basic_pulses",    mon_pulses, 11);
            chk("basic_init_cnt",  mon_init, 1);
            chk("basic_final_cnt", mon_final, 1);
            chk("basic_err_cnt",   mon_err, 0);
          end
          2: begin
            chk("lat3_out_cycle", mon_out_cyc, 45);
            chk("lat3_out_data",  mon_out_data, lit_z);
            chk("lat3_pulses",    mon_pulses, 11);
          end
          3: begin
            chk("stall_out_cycle", mon_out_cyc, 62);
            chk("stall_out_data",  mon_out_data, lit_a);
            chk("stall_err_cnt",   mon_err, 0);
          end
          4: begin
            chk("tmo_err_cnt",   mon_err, 1);
            chk("tmo_err_cycle", mon_err_rel, 24);
            chk("tmo_no_out",    mon_out_cyc, -1);
            chk("tmo_pulses",    mon_pulses, 4);
          end
          5: begin
            chk("expiry_out_cycle", mon_out_cyc, 38);
            chk("expiry_out_data",  mon_out_data, lit_a);
            chk("expiry_err_cnt",   mon_err, 0);
          end
          7: begin
            chk("bp_out_cycle", mon_out_cyc, 23);
            chk("bp_out_data",  mon_out_data, lit_b);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic send(logic [127:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(int limit);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < limit) begin @(negedge clk); n++; end
  endtask

  task automatic wait_err(int limit);
    int n = 0;
    while (bus.err !== 1'b1 && n < limit) begin @(negedge clk); n++; end
  endtask

  task automatic lit(int kind);
    lit_kind = kind;
    lit_req++;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_lat(int l);
    for (int i = 0; i < 16; i++) lat[i] = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    set_lat(1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic block, L=1, no backpressure.
    send(128'h00112233445566778899aabbccddeeff);
    wait_out(200);
    @(negedge clk);
    lit(1);

    // Backpressure: out_ready low for 5 cycles after out_valid.
    bus.out_ready = 1'b0;
    send(128'hffeeddccbbaa99887766554433221100);
    wait_out(200);
    repeat (5) @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    lit(7);

    // Stray return while idle, then a block through an L=3 round unit.
    stray_due = cyc + 1;
    repeat (3) @(negedge clk);
    set_lat(3);
    send(128'h0);
    wait_out(300);
    @(negedge clk);
    lit(2);

    // Long stall on round 3.
    set_lat(1);
`ifdef AES_SEQ_TIMEOUT_EN
    lat[3] = 0;
    send(128'h00112233445566778899aabbccddeeff);
    wait_err(200);
    repeat (3) @(negedge clk);
    lit(4);
    lat[3] = TIMEOUT;
    send(128'h00112233445566778899aabbccddeeff);
    wait_out(300);
    @(negedge clk);
    lit(5);
`else
    lat[3] = 40;
    send(128'h00112233445566778899aabbccddeeff);
    wait_out(300);
    @(negedge clk);
    lit(3);
`endif

    // Reset during round 5 WAIT; the stub's return lands one cycle later.
    set_lat(1);
    lat[5] = 3;
    send(128'hffeeddccbbaa99887766554433221100);
    begin
      int n = 0;
      while (!(bus.rnd_valid === 1'b1 && bus.rnd_idx == 4'd5) && n < 200) begin
        @(negedge clk); n++;
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    set_lat(1);
    send(128'h00112233445566778899aabbccddeeff);
    wait_out(200);
    @(negedge clk);
    lit(1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
Iterative AES-128 round controller. Accepts one 128-bit block and sequences it NR+1 times through an external single-round datapath (AddRoundKey / SubBytes / ShiftRows / MixColumns unit with valid-in/valid-out and fixed latency). It drives the round index and the initial/final-round controls, holds the state between rounds, and returns the finished block over a valid/ready output. It sits between the block-input interface and the shared round datapath.

Parameters:
NR, 10, number of full rounds; rounds are issued with index 0..NR.
TIMEOUT, 16, max cycles in WAIT before abort; used only with AES_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input block valid
in_ready  out  1  controller can accept a block
in_data  in  128  plaintext block (byte 0 at [127:120])
rnd_valid  out  1  one-cycle issue strobe to the round datapath
rnd_data  out  128  state presented to the round datapath
rnd_idx  out  4  round index 0..NR, for key select
rnd_init  out  1  rnd_idx==0: datapath performs AddRoundKey only
rnd_final  out  1  rnd_idx==NR: datapath bypasses MixColumns
rnd_ret_valid  in  1  round datapath result valid
rnd_ret_data  in  128  round datapath result
out_valid  out  1  finished block valid
out_ready  in  1  downstream accepts the block
out_data  out  128  ciphertext block
busy  out  1  state != IDLE
err  out  1  one-cycle timeout pulse (0 without macro)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE, round counter=0, state register=0, rnd_valid=0, out_valid=0, err=0, busy=0. in_ready=1 from the first cycle after reset. Reset mid-block drops the block. A late rnd_ret_valid after reset is ignored.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: state_reg<=in_data, rnd_cnt<=0, go ISSUE.
  - ISSUE: rnd_valid=1 for exactly one cycle. rnd_data=state_reg, rnd_idx=rnd_cnt. Go WAIT.
  - WAIT: on rnd_ret_valid, state_reg<=rnd_ret_data. If rnd_cnt==NR go DONE; else rnd_cnt+=1 and go ISSUE.
  - DONE: out_valid=1, out_data=state_reg, both held stable until out_ready. On out_valid&out_ready go IDLE. in_ready=1 again on the next cycle; there is no same-cycle accept.
- in_ready=0 in ISSUE, WAIT and DONE.
- rnd_init and rnd_final are combinational from rnd_cnt. They are valid whenever rnd_valid=1.
- rnd_ret_valid outside WAIT is ignored and has no state change.
- Round unit latency L ≥ 1:
  - Block accepted in cycle 0; round k issued in cycle 1+k(L+1).
  - out_valid first high in cycle 1+(NR+1)(L+1). With L=1, NR=10 that is cycle 23.
- rnd_cnt is 4 bits, never exceeds NR, and has no wrap.
- Back-to-back blocks: the minimum gap between accepts is the full latency plus one IDLE cycle.

Optional Feature:
AES_SEQ_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without rnd_ret_valid.
  - When it reaches TIMEOUT, err=1 for one cycle and the FSM goes to IDLE with the block discarded.
  - If rnd_ret_valid arrives in the expiry cycle, the return wins and there is no err.
- Undefined: WAIT persists indefinitely, err is tied to 0, and there is no wait counter.

Test Plan:
- Basic block: stub round unit (L=1, ret_data = rnd_data ^ {16{4'h0,rnd_idx}}); accept in_data=128'h00112233445566778899aabbccddeeff with out_ready=1 -> out_valid in cycle 23, out_data = in_data ^ {16{8'h0B}}, err=0.
- Control sequence: same stimulus -> exactly 11 rnd_valid pulses with rnd_idx 0..10; rnd_init only at idx 0; rnd_final only at idx 10.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 and busy=1 throughout; in_ready=1 the cycle after the handshake.
- Stray and latency: assert rnd_ret_valid in IDLE with data 128'hFF.. -> no state change; stub L=3 -> out_valid at cycle 1+11·4=45 with the correct result.
- Reset mid-block: assert reset during round 5 WAIT -> next cycle all outputs at reset values; a stub return one cycle later is ignored; a new block then completes correctly.
- Timeout (macro defined, TIMEOUT=16): stub never returns for round 3 -> err pulses exactly once 16 cycles after entering WAIT, FSM returns to IDLE, in_ready=1; with the return in the expiry cycle -> no err and the block completes.
